// File: rtl/subfil_pkg.sv
// Shared definitions for the polyphase filter family: sequencer state codes,
// MAC pipeline depth and the round-half-to-even narrowing function.
package subfil_pkg;

  // Sequencer state encoding.
  localparam logic [1:0] SEQ_IDLE  = 2'd0;
  localparam logic [1:0] SEQ_RUN   = 2'd1;
  localparam logic [1:0] SEQ_DRAIN = 2'd2;

  // Cycles from the last issued address pair to the sequencer going idle:
  // RAM read, product, accumulate, output register.
  localparam int DRAIN_CYC = 4;

  // Working width of round_even; accumulators must fit inside it.
  localparam int RND_MAXW = 64;

  // Narrow an aw-bit two's complement value (sign-extended into val) to ow
  // bits after discarding its shift MSBs. When bits are left over below the
  // kept field they are rounded half-to-even; overflow wraps. The caller takes
  // the low ow bits of the result.
  function automatic logic [RND_MAXW-1:0] round_even(
    input logic [RND_MAXW-1:0] val,
    input int                  aw,
    input int                  ow,
    input int                  shift
  );
    logic [RND_MAXW-1:0] r;
    logic [RND_MAXW-1:0] mask;
    logic                up;
    int                  kw;
    int                  dw;
    kw = aw - shift;
    dw = kw - ow;
    r  = val;
    if (dw <= 0) begin
      // Nothing to round: re-extend from the new sign bit.
      for (int i = 0; i < RND_MAXW; i++) begin
        if (i >= kw) r[i] = val[kw-1];
      end
    end else begin
      mask = (RND_MAXW'(1) << (dw - 1)) - RND_MAXW'(1);
      up   = val[dw-1] && (((val & mask) != '0) || val[dw]);
      r    = (val >> dw) + RND_MAXW'(up);
    end
    return r;
  endfunction

endpackage

// File: rtl/subfil_mac.sv
// Multiply-accumulate back end shared by the up- and down-sampling filters:
// registered product, accumulator that loads on the first tap of a sum and
// adds on the rest, and a rounded output register strobed on the last tap.
module subfil_mac
  import subfil_pkg::*;
#(
  parameter int IW    = 16,
  parameter int CW    = 12,
  parameter int AW    = 32,
  parameter int OW    = 24,
  parameter int SHIFT = 2
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic                 i_v,
  input  logic                 i_first,
  input  logic                 i_last,
  input  logic signed [IW-1:0] i_data,
  input  logic signed [CW-1:0] i_coef,
  output logic                 o_ce,
  output logic        [OW-1:0] o_result
);

  localparam int PW = IW + CW;

  logic signed [PW-1:0] r_prod;
  logic                 r_p_v;
  logic                 r_p_first;
  logic                 r_p_last;
  logic signed [AW-1:0] r_acc;
  logic                 r_a_v;
  logic                 r_a_last;
  logic signed [AW-1:0] w_prod_ext;
  logic        [OW-1:0] w_round;

  assign w_prod_ext = AW'(r_prod);
  assign w_round    = OW'(round_even(RND_MAXW'(r_acc), AW, OW, SHIFT));

  // Product stage: one signed multiply per clock.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_p_v     <= 1'b0;
      r_p_first <= 1'b0;
      r_p_last  <= 1'b0;
      r_prod    <= '0;
    end else begin
      r_p_v     <= i_v;
      r_p_first <= i_first;
      r_p_last  <= i_last;
      r_prod    <= i_data * i_coef;
    end
  end

  // Accumulate stage: the first tap overwrites so sums run back to back.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_a_v    <= 1'b0;
      r_a_last <= 1'b0;
      r_acc    <= '0;
    end else begin
      r_a_v    <= r_p_v;
      r_a_last <= r_p_last;
      if (r_p_v) r_acc <= r_p_first ? w_prod_ext : r_acc + w_prod_ext;
    end
  end

  // Output stage: capture the completed sum and pulse o_ce for one clock.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_ce     <= 1'b0;
      o_result <= '0;
    end else begin
      o_ce <= r_a_v && r_a_last;
      if (r_a_v && r_a_last) o_result <= w_round;
    end
  end

endmodule

// File: rtl/subfilup.sv
// Polyphase 1:NUP interpolating FIR. Each accepted input sample produces NUP
// outputs; phase p sums h[p+k*NUP]*x[n-k] over k using one shared multiplier.
//
// Input handshake: i_ce is a one-cycle strobe and o_busy acts as an inverted
// ready. A strobe seen while o_busy is low is taken; a strobe while o_busy is
// high is dropped and latches o_overrun until reset. o_ce is a one-cycle
// valid for o_result with no back-pressure.
module subfilup
  import subfil_pkg::*;
#(
  parameter int    IW             = 16,
  parameter int    OW             = 24,
  parameter int    CW             = 12,
  parameter int    NUP            = 4,
  parameter int    NCOEFFS        = 96,
  parameter bit    FIXED_COEFFS   = 1'b0,
  parameter string INITIAL_COEFFS = "",
  parameter int    SHIFT          = 2
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          i_wr_coeff,
  input  logic [CW-1:0] i_coeff,
  input  logic          i_ce,
  input  logic [IW-1:0] i_sample,
  output logic          o_busy,
  output logic          o_overrun,
  output logic          o_ce,
  output logic [OW-1:0] o_result
);

  localparam int NTAPS   = (NCOEFFS + NUP - 1) / NUP;
  localparam int LGNTAPS = (NTAPS > 1) ? $clog2(NTAPS) : 1;
  localparam int DDEPTH  = 1 << LGNTAPS;
  localparam int NSLOT   = NUP * NTAPS;
  localparam int CAW     = $clog2(NSLOT);
  localparam int IXW     = (NCOEFFS > 1) ? $clog2(NCOEFFS) : 1;
  localparam int PHW     = $clog2(NUP);
  localparam int AW      = IW + CW + LGNTAPS;

  typedef logic [CW-1:0] cmem_t [NCOEFFS];

  // Power-up contents of the coefficient memory: zeros.
  function automatic cmem_t f_cmem_init();
    cmem_t m;
    foreach (m[i]) m[i] = '0;
    return m;
  endfunction

  cmem_t                r_cmem = f_cmem_init();
  logic signed [IW-1:0] r_dmem [DDEPTH] = '{default: '0};

  logic [1:0]           r_state;
  logic [PHW-1:0]       r_phase;
  logic [LGNTAPS-1:0]   r_tap;
  logic [1:0]           r_drain;
  logic [LGNTAPS-1:0]   r_wptr;
  logic [LGNTAPS-1:0]   r_newest;
  logic                 r_overrun;

  logic                 r_rd_v;
  logic                 r_rd_first;
  logic                 r_rd_last;
  logic signed [IW-1:0] r_rd_data;
  logic signed [CW-1:0] r_rd_coef;

  logic                 w_accept;
  logic                 w_drop;
  logic                 w_last_tap;
  logic                 w_last_phase;
  logic [CAW-1:0]       w_caddr;
  logic [LGNTAPS-1:0]   w_daddr;
  logic                 w_coef_valid;

  assign w_accept     = i_ce && (r_state == SEQ_IDLE);
  assign w_drop       = i_ce && (r_state != SEQ_IDLE);
  assign w_last_tap   = (r_tap == LGNTAPS'(NTAPS - 1));
  assign w_last_phase = (r_phase == PHW'(NUP - 1));
  assign w_caddr      = CAW'(int'(r_phase) + int'(r_tap) * NUP);
  assign w_daddr      = r_newest - r_tap;
  assign w_coef_valid = (int'(w_caddr) < NCOEFFS);

  assign o_busy    = (r_state != SEQ_IDLE);
  assign o_overrun = r_overrun;

  // Data RAM: an accepted sample lands at the write pointer.
  always_ff @(posedge i_clk) begin
    if (w_accept) r_dmem[r_wptr] <= i_sample;
  end

  generate
    if (!FIXED_COEFFS) begin : g_coef_wr
      logic [IXW-1:0] r_cidx;

      // Coefficient index: steps on each write and wraps at NCOEFFS.
      always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
          r_cidx <= '0;
        end else if (i_wr_coeff) begin
          r_cidx <= (r_cidx == IXW'(NCOEFFS - 1)) ? '0 : r_cidx + 1'b1;
        end
      end

      // Coefficient RAM write port.
      always_ff @(posedge i_clk) begin
        if (i_wr_coeff) r_cmem[r_cidx] <= i_coeff;
      end
    end
  endgenerate

  // Sequencer: walks tap k inside phase p, then waits for the pipeline.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state   <= SEQ_IDLE;
      r_phase   <= '0;
      r_tap     <= '0;
      r_drain   <= '0;
      r_newest  <= '0;
      r_wptr    <= '0;
      r_overrun <= 1'b0;
    end else begin
      case (r_state)
        SEQ_IDLE: begin
          if (i_ce) begin
            r_state  <= SEQ_RUN;
            r_phase  <= '0;
            r_tap    <= '0;
            r_newest <= r_wptr;
          end
        end
        SEQ_RUN: begin
          if (w_last_tap) begin
            r_tap <= '0;
            if (w_last_phase) begin
              r_phase <= '0;
              r_drain <= '0;
              r_state <= SEQ_DRAIN;
            end else begin
              r_phase <= r_phase + 1'b1;
            end
          end else begin
            r_tap <= r_tap + 1'b1;
          end
        end
        SEQ_DRAIN: begin
          if (r_drain == 2'(DRAIN_CYC - 1)) r_state <= SEQ_IDLE;
          else                              r_drain <= r_drain + 1'b1;
        end
        default: r_state <= SEQ_IDLE;
      endcase
      if (w_accept) r_wptr    <= r_wptr + 1'b1;
      if (w_drop)   r_overrun <= 1'b1;
    end
  end

  // Registered RAM reads; coefficient slots past NCOEFFS read as zero.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_rd_v     <= 1'b0;
      r_rd_first <= 1'b0;
      r_rd_last  <= 1'b0;
      r_rd_data  <= '0;
      r_rd_coef  <= '0;
    end else begin
      r_rd_v     <= (r_state == SEQ_RUN);
      r_rd_first <= (r_tap == '0);
      r_rd_last  <= w_last_tap;
      r_rd_data  <= r_dmem[w_daddr];
      r_rd_coef  <= w_coef_valid ? r_cmem[w_caddr] : '0;
    end
  end

  subfil_mac #(
    .IW    (IW),
    .CW    (CW),
    .AW    (AW),
    .OW    (OW),
    .SHIFT (SHIFT)
  ) u_mac (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_v       (r_rd_v),
    .i_first   (r_rd_first),
    .i_last    (r_rd_last),
    .i_data    (r_rd_data),
    .i_coef    (r_rd_coef),
    .o_ce      (o_ce),
    .o_result  (o_result)
  );

endmodule

// File: tb/tb_subfilup.sv
// Bench for subfilup with IW=8, CW=8, NUP=4, NCOEFFS=12, SHIFT=0, OW=18.
// A behavioural model of the data RAM and coefficient table predicts every
// output; expected values queue up as samples are driven and are popped as
// o_ce pulses appear.
module tb_subfilup;

  localparam int IW  = 8;
  localparam int CW  = 8;
  localparam int OW  = 18;
  localparam int NUP = 4;
  localparam int NC  = 12;
  localparam int NT  = 3;
  localparam int DD  = 4;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_wr_coeff;
  logic [CW-1:0] i_coeff;
  logic          i_ce;
  logic [IW-1:0] i_sample;
  logic          o_busy;
  logic          o_overrun;
  logic          o_ce;
  logic [OW-1:0] o_result;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  subfilup #(
    .IW             (IW),
    .OW             (OW),
    .CW             (CW),
    .NUP            (NUP),
    .NCOEFFS        (NC),
    .FIXED_COEFFS   (1'b0),
    .INITIAL_COEFFS (""),
    .SHIFT          (0)
  ) dut (
    .i_clk      (clk),
    .i_reset_n  (rst_n),
    .i_wr_coeff (i_wr_coeff),
    .i_coeff    (i_coeff),
    .i_ce       (i_ce),
    .i_sample   (i_sample),
    .o_busy     (o_busy),
    .o_overrun  (o_overrun),
    .o_ce       (o_ce),
    .o_result   (o_result)
  );

  // ---------------- model and scoreboard ----------------
  logic [CW-1:0] mdl_h [NC];
  logic [IW-1:0] mdl_ram [DD];
  int            mdl_wptr = 0;
  int            mdl_idx  = 0;
  logic [OW-1:0] exp_q [$];
  logic [OW-1:0] obs_q [$];
  int            ce_cyc_q [$];
  int            total = 0;
  int            bad   = 0;
  int            t_send = 0;

  initial begin
    foreach (mdl_ram[i]) mdl_ram[i] = '0;
    foreach (mdl_h[i])   mdl_h[i]   = '0;
  end

  // Every o_ce is checked against the head of the expected queue.
  always @(negedge clk) begin
    logic [OW-1:0] e;
    if (o_ce) begin
      ce_cyc_q.push_back(cyc);
      obs_q.push_back(o_result);
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_oce: result=%0d arrived with no expected value", o_result);
      end else begin
        e = exp_q.pop_front();
        if (o_result !== e) begin
          bad++;
          $display("FAIL scoreboard: result=%0d expected=%0d", o_result, e);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wr_coeff(input logic [CW-1:0] v);
    @(negedge clk);
    i_wr_coeff = 1'b1;
    i_coeff    = v;
    mdl_h[mdl_idx] = v;
    mdl_idx = (mdl_idx + 1) % NC;
    @(negedge clk);
    i_wr_coeff = 1'b0;
  endtask

  task automatic load_ramp();
    for (int c = 0; c < NC; c++) wr_coeff(CW'(c + 1));
  endtask

  // Drive one i_ce strobe; when accepted, update the model RAM and, if asked,
  // queue the NUP outputs that sample should produce.
  task automatic send(input logic [IW-1:0] x, input bit accept, input bit push_exp);
    int newest;
    int s;
    int c;
    @(negedge clk);
    i_ce     = 1'b1;
    i_sample = x;
    t_send   = cyc;
    if (accept) begin
      mdl_ram[mdl_wptr] = x;
      newest   = mdl_wptr;
      mdl_wptr = (mdl_wptr + 1) % DD;
      if (push_exp) begin
        for (int p = 0; p < NUP; p++) begin
          s = 0;
          for (int k = 0; k < NT; k++) begin
            c = p + k * NUP;
            if (c < NC)
              s += int'($signed(mdl_h[c])) * int'($signed(mdl_ram[(newest - k + DD) % DD]));
          end
          exp_q.push_back(OW'(s));
        end
      end
    end
    @(negedge clk);
    i_ce = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    i_ce = 1'b0; i_sample = '0; i_wr_coeff = 1'b0; i_coeff = '0;
    idle(3);
    total++; if (o_busy !== 1'b0)    begin bad++; $display("FAIL reset_busy: got=%b want=0", o_busy); end
    total++; if (o_overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun: got=%b want=0", o_overrun); end
    total++; if (o_ce !== 1'b0)      begin bad++; $display("FAIL reset_ce: got=%b want=0", o_ce); end
    total++; if (o_result !== '0)    begin bad++; $display("FAIL reset_result: got=%0d want=0", o_result); end
    rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_impulse();
    int t0;
    obs_q.delete(); ce_cyc_q.delete();
    send(8'd1, 1'b1, 1'b1);
    t0 = t_send;
    total++; if (o_busy !== 1'b1) begin bad++; $display("FAIL impulse_busy_t1: got=%b want=1", o_busy); end
    idle(18);
    total++;
    if (ce_cyc_q.size() != NUP) begin
      bad++; $display("FAIL impulse_ce_count: got=%0d want=%0d", ce_cyc_q.size(), NUP);
    end else begin
      total++;
      if (ce_cyc_q[0] - t0 != 7) begin bad++; $display("FAIL impulse_latency: got=%0d want=7", ce_cyc_q[0] - t0); end
      for (int i = 1; i < NUP; i++) begin
        total++;
        if (ce_cyc_q[i] - ce_cyc_q[i-1] != 3) begin
          bad++; $display("FAIL impulse_spacing%0d: got=%0d want=3", i, ce_cyc_q[i] - ce_cyc_q[i-1]);
        end
      end
    end
    for (int j = 0; j < 3; j++) begin
      send(8'd0, 1'b1, 1'b1);
      idle(18);
    end
    total++;
    if (obs_q.size() != 16) begin
      bad++; $display("FAIL impulse_outputs: got=%0d want=16", obs_q.size());
    end else begin
      for (int i = 0; i < 16; i++) begin
        total++;
        if (obs_q[i] !== OW'((i < 12) ? i + 1 : 0)) begin
          bad++; $display("FAIL impulse_value%0d: got=%0d want=%0d", i, obs_q[i], (i < 12) ? i + 1 : 0);
        end
      end
    end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL impulse_drain: left=%0d want=0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_dc();
    obs_q.delete();
    for (int j = 0; j < 4; j++) begin
      send(8'd2, 1'b1, 1'b1);
      idle(18);
    end
    total++;
    if (obs_q.size() != 16) begin
      bad++; $display("FAIL dc_outputs: got=%0d want=16", obs_q.size());
    end else begin
      for (int p = 0; p < NUP; p++) begin
        total++;
        if (obs_q[12 + p] !== OW'(30 + 6 * p)) begin
          bad++; $display("FAIL dc_phase%0d: got=%0d want=%0d", p, obs_q[12 + p], 30 + 6 * p);
        end
      end
    end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL dc_drain: left=%0d want=0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_sign();
    obs_q.delete();
    for (int c = 0; c < NC; c++) wr_coeff(8'h80);
    for (int j = 0; j < 3; j++) begin
      send(8'h80, 1'b1, 1'b1);
      idle(18);
    end
    total++;
    if (obs_q.size() != 12) begin
      bad++; $display("FAIL sign_outputs: got=%0d want=12", obs_q.size());
    end else begin
      for (int p = 0; p < NUP; p++) begin
        total++;
        if (obs_q[8 + p] !== OW'(49152)) begin
          bad++; $display("FAIL sign_phase%0d: got=%0d want=49152", p, obs_q[8 + p]);
        end
      end
    end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL sign_drain: left=%0d want=0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_overrun();
    obs_q.delete();
    load_ramp();
    total++; if (o_overrun !== 1'b0) begin bad++; $display("FAIL overrun_pre: got=%b want=0", o_overrun); end
    send(8'd5, 1'b1, 1'b1);
    idle(3);
    send(8'd9, 1'b0, 1'b0);
    total++; if (o_overrun !== 1'b1) begin bad++; $display("FAIL overrun_set: got=%b want=1", o_overrun); end
    idle(20);
    total++; if (obs_q.size() != NUP) begin bad++; $display("FAIL overrun_outputs: got=%0d want=%0d", obs_q.size(), NUP); end
    total++; if (o_overrun !== 1'b1) begin bad++; $display("FAIL overrun_sticky: got=%b want=1", o_overrun); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL overrun_drain: left=%0d want=0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_reset_abort();
    obs_q.delete(); ce_cyc_q.delete();
    send(8'd3, 1'b1, 1'b0);
    idle(5);
    rst_n = 1'b0;
    #1;
    total++; if (o_busy !== 1'b0)    begin bad++; $display("FAIL abort_busy: got=%b want=0", o_busy); end
    total++; if (o_result !== '0)    begin bad++; $display("FAIL abort_result: got=%0d want=0", o_result); end
    total++; if (o_overrun !== 1'b0) begin bad++; $display("FAIL abort_overrun: got=%b want=0", o_overrun); end
    mdl_wptr = 0;
    mdl_idx  = 0;
    idle(3);
    rst_n = 1'b1;
    idle(20);
    total++; if (ce_cyc_q.size() != 0) begin bad++; $display("FAIL abort_no_oce: got=%0d want=0", ce_cyc_q.size()); end
    send(8'd4, 1'b1, 1'b1);
    idle(18);
    total++; if (obs_q.size() != NUP) begin bad++; $display("FAIL abort_restart: got=%0d want=%0d", obs_q.size(), NUP); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL abort_drain: left=%0d want=0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_coeff_wrap();
    obs_q.delete();
    load_ramp();
    wr_coeff(8'h7F);
    send(8'd0, 1'b1, 1'b1); idle(18);
    send(8'd0, 1'b1, 1'b1); idle(18);
    send(8'd1, 1'b1, 1'b1); idle(18);
    total++;
    if (obs_q.size() != 12) begin
      bad++; $display("FAIL wrap_outputs: got=%0d want=12", obs_q.size());
    end else begin
      total++; if (obs_q[8]  !== OW'(127)) begin bad++; $display("FAIL wrap_phase0: got=%0d want=127", obs_q[8]); end
      total++; if (obs_q[9]  !== OW'(2))   begin bad++; $display("FAIL wrap_phase1: got=%0d want=2", obs_q[9]); end
      total++; if (obs_q[11] !== OW'(4))   begin bad++; $display("FAIL wrap_phase3: got=%0d want=4", obs_q[11]); end
    end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL wrap_drain: left=%0d want=0", exp_q.size()); exp_q.delete(); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    load_ramp();
    test_impulse();
    test_dc();
    test_sign();
    test_overrun();
    test_reset_abort();
    test_coeff_wrap();
    idle(5);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    bad++;
    $display("FAIL watchdog: cycle=%0d limit reached", cyc);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
